// File: rtl/f2i_arb_pkg.sv
// Shared types for the round-robin float-to-int8 block arbiter.
// ch_idx_t is sized from the default channel count; wider channel counts need a matching edit here.
package f2i_arb_pkg;

    localparam int NUM_CH_DEF  = 3;
    localparam int BLK_LEN_DEF = 64;
    localparam int CVT_LAT_DEF = 4;
    localparam int CH_W        = (NUM_CH_DEF > 1) ? $clog2(NUM_CH_DEF) : 1;

    typedef logic [CH_W-1:0] ch_idx_t;

    typedef struct packed {
        logic    valid;
        ch_idx_t ch;
        logic    last;
    } tag_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/f2i_tag_delay.sv
// Fixed-depth shift line of routing tags; its head lines up with the converter result.
module f2i_tag_delay
    import f2i_arb_pkg::*;
#(
    parameter int DEPTH = CVT_LAT_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stages [DEPTH];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/f2i_rr_block_arbiter.sv
// Shares one float32->int8 converter among NUM_CH streams, granting whole blocks
// round-robin and routing converter results back to the owning channel.
module f2i_rr_block_arbiter
    import f2i_arb_pkg::*;
#(
    parameter int NUM_CH  = NUM_CH_DEF,
    parameter int BLK_LEN = BLK_LEN_DEF,
    parameter int CVT_LAT = CVT_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NUM_CH*32-1:0] req_data,
    input  logic [NUM_CH-1:0]    req_valid,
    output logic [NUM_CH-1:0]    req_ready,
    output logic [31:0]          cvt_din,
    output logic                 cvt_din_valid,
    input  logic [7:0]           cvt_dout,
    input  logic                 cvt_dout_valid,
    output logic [7:0]           out_data,
    output logic [NUM_CH-1:0]    out_valid,
    output logic [NUM_CH-1:0]    out_last,
    output logic                 sync_err
);

    localparam int      BEAT_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;
    localparam ch_idx_t LAST_CH = ch_idx_t'(NUM_CH - 1);

    state_t              state, next_state;
    ch_idx_t             gnt, rr_ptr, scan_ch, cand;
    logic                scan_hit;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                xfer, blk_end;
    logic [31:0]         sel_data;
    tag_t                tag_push, tag_head;

    assign xfer    = |(req_valid & req_ready);
    assign blk_end = xfer && (beat_cnt == BEAT_W'(BLK_LEN - 1));

    // Lowest rotation offset from rr_ptr wins, so the loop runs downward and the last hit sticks.
    always_comb begin
        scan_hit = 1'b0;
        scan_ch  = rr_ptr;
        cand     = rr_ptr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = ch_idx_t'((int'(rr_ptr) + k) % NUM_CH);
            if (req_valid[cand]) begin
                scan_hit = 1'b1;
                scan_ch  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (scan_hit) next_state = BURST;
            BURST:   if (blk_end)  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state == BURST) begin
            req_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            gnt      <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && scan_hit) begin
                gnt <= scan_ch;
            end
            if (blk_end) begin
                beat_cnt <= '0;
                rr_ptr   <= (gnt == LAST_CH) ? '0 : gnt + 1'b1;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt == ch_idx_t'(i)) begin
                sel_data = req_data[i*32 +: 32];
            end
        end
    end

    // The tag enters the delay line one cycle after the transfer, in step with cvt_din_valid.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cvt_din       <= '0;
            cvt_din_valid <= 1'b0;
            tag_push      <= '0;
        end else begin
            cvt_din_valid  <= xfer;
            tag_push.valid <= xfer;
            tag_push.ch    <= gnt;
            tag_push.last  <= blk_end;
            if (xfer) begin
                cvt_din <= sel_data;
            end
        end
    end

    f2i_tag_delay #(
        .DEPTH (CVT_LAT)
    ) u_tag_delay (
        .clk     (clk),
        .nrst    (nrst),
        .tag_in  (tag_push),
        .tag_out (tag_head)
    );

    // On a tag mismatch the converter valid still drives the output, routed by the head tag.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_data  <= '0;
            out_valid <= '0;
            out_last  <= '0;
            sync_err  <= 1'b0;
        end else begin
            out_valid <= '0;
            out_last  <= '0;
            if (cvt_dout_valid) begin
                out_data                <= cvt_dout;
                out_valid[tag_head.ch]  <= 1'b1;
                out_last[tag_head.ch]   <= tag_head.last;
            end
            if (cvt_dout_valid != tag_head.valid) begin
                sync_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_f2i_rr_block_arbiter.sv
// Directed bench for f2i_rr_block_arbiter with a table-driven converter model.
module tb_f2i_rr_block_arbiter;

    localparam int NUM_CH  = 3;
    localparam int BLK_LEN = 64;
    localparam int CVT_LAT = 4;

    logic                 clk = 1'b0;
    logic                 nrst;
    logic [NUM_CH*32-1:0] req_data;
    logic [NUM_CH-1:0]    req_valid;
    logic [NUM_CH-1:0]    req_ready;
    logic [31:0]          cvt_din;
    logic                 cvt_din_valid;
    logic [7:0]           cvt_dout;
    logic                 cvt_dout_valid;
    logic [7:0]           out_data;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH-1:0]    out_last;
    logic                 sync_err;

    f2i_rr_block_arbiter #(
        .NUM_CH  (NUM_CH),
        .BLK_LEN (BLK_LEN),
        .CVT_LAT (CVT_LAT)
    ) dut (
        .clk            (clk),
        .nrst           (nrst),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .cvt_din        (cvt_din),
        .cvt_din_valid  (cvt_din_valid),
        .cvt_dout       (cvt_dout),
        .cvt_dout_valid (cvt_dout_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_last       (out_last),
        .sync_err       (sync_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Converter stand-in: fixed-latency pipe with a small lookup of the float values used here.
    function automatic logic [7:0] gold_convert(input logic [31:0] f);
        case (f)
            32'h3F800000: return 8'h01;
            32'h40000000: return 8'h02;
            32'h40400000: return 8'h03;
            32'h40A00000: return 8'h05;
            32'hC0000000: return 8'hFE;
            32'h42FECCCD: return 8'h7F;
            default:      return 8'h00;
        endcase
    endfunction

    logic [8:0] cvt_pipe [CVT_LAT];
    logic       inject_valid = 1'b0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < CVT_LAT; i++) cvt_pipe[i] <= '0;
        end else begin
            cvt_pipe[0] <= {cvt_din_valid | inject_valid, gold_convert(cvt_din)};
            for (int i = 1; i < CVT_LAT; i++) cvt_pipe[i] <= cvt_pipe[i-1];
        end
    end

    assign cvt_dout_valid = cvt_pipe[CVT_LAT-1][8];
    assign cvt_dout       = cvt_pipe[CVT_LAT-1][7:0];

    int          remaining [NUM_CH];
    int          sent      [NUM_CH];
    logic [31:0] val_a     [NUM_CH];
    logic [31:0] val_b     [NUM_CH];
    logic [7:0]  exp_a     [NUM_CH];
    logic [7:0]  exp_b     [NUM_CH];
    logic [NUM_CH-1:0] pause;
    int idle_cnt;
    int first_xfer_cyc;

    int rcv      [NUM_CH];
    int last_cnt [NUM_CH];
    int data_err = 0;
    int last_err = 0;
    int oh_err   = 0;
    int first_out_cyc = -1;
    int blk_order [$];
    logic [7:0] ch2_data [$];

    int checks = 0;
    int passed = 0;

    // Output monitor: per-channel ordering, data, out_last placement and block order.
    always @(negedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                rcv[i]      = 0;
                last_cnt[i] = 0;
            end
            data_err      = 0;
            last_err      = 0;
            oh_err        = 0;
            first_out_cyc = -1;
            blk_order.delete();
            ch2_data.delete();
        end else begin
            if (!$onehot0(out_valid)) oh_err++;
            for (int i = 0; i < NUM_CH; i++) begin
                if (out_last[i] && !out_valid[i]) last_err++;
                if (out_valid[i]) begin
                    if (first_out_cyc < 0) first_out_cyc = cyc;
                    if (out_data !== (rcv[i][0] ? exp_b[i] : exp_a[i])) data_err++;
                    rcv[i]++;
                    if (out_last[i] != ((rcv[i] % BLK_LEN) == 0)) last_err++;
                    if (out_last[i]) begin
                        last_cnt[i]++;
                        blk_order.push_back(i);
                    end
                    if (i == 2 && ch2_data.size() < 2) ch2_data.push_back(out_data);
                end
            end
        end
    end

    function automatic logic [63:0] order_code();
        logic [63:0] c;
        c = '0;
        foreach (blk_order[k]) c = (c << 4) | 64'(blk_order[k] + 1);
        return c;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveInputs();
        for (int i = 0; i < NUM_CH; i++) begin
            req_valid[i]         = (remaining[i] > 0) && !pause[i];
            req_data[i*32 +: 32] = sent[i][0] ? val_b[i] : val_a[i];
        end
    endtask

    task automatic applyStimulus(input int ch, input int count, input logic [31:0] va, input logic [31:0] vb,
                                 input logic [7:0] ea, input logic [7:0] eb);
        remaining[ch] = count;
        sent[ch]      = 0;
        val_a[ch]     = va;
        val_b[ch]     = vb;
        exp_a[ch]     = ea;
        exp_b[ch]     = eb;
        driveInputs();
    endtask

    task automatic tick();
        logic [NUM_CH-1:0] x;
        x = req_valid & req_ready;
        if (req_valid != '0 && req_ready == '0) idle_cnt++;
        if (x != '0 && first_xfer_cyc < 0) first_xfer_cyc = cyc;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (x[i]) begin
                sent[i]++;
                remaining[i]--;
            end
        end
        driveInputs();
    endtask

    task automatic doReset();
        nrst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            remaining[i] = 0;
            sent[i]      = 0;
            val_a[i]     = '0;
            val_b[i]     = '0;
            exp_a[i]     = '0;
            exp_b[i]     = '0;
        end
        pause          = '0;
        idle_cnt       = 0;
        first_xfer_cyc = -1;
        driveInputs();
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    task automatic runUntilIdle(input string tag, input int budget);
        int n;
        n = 0;
        while ((remaining[0] + remaining[1] + remaining[2]) > 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, " finished within budget"}, 64'(n < budget), 64'd1);
        repeat (CVT_LAT + 4) tick();
    endtask

    task automatic checkClean(input string tag);
        checkOutput({tag, " data errors"}, 64'(data_err), 64'd0);
        checkOutput({tag, " last errors"}, 64'(last_err), 64'd0);
        checkOutput({tag, " onehot errors"}, 64'(oh_err), 64'd0);
        checkOutput({tag, " sync_err"}, 64'(sync_err), 64'd0);
    endtask

    initial begin
        int n;
        req_valid = '0;
        req_data  = '0;
        doReset();
        nrst = 1'b0;
        #1;
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        checkOutput("reset cvt_din_valid", 64'(cvt_din_valid), 64'd0);
        checkOutput("reset cvt_din", 64'(cvt_din), 64'd0);
        checkOutput("reset out_data", 64'(out_data), 64'd0);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset out_last", 64'(out_last), 64'd0);
        checkOutput("reset sync_err", 64'(sync_err), 64'd0);

        $display("[TB] single channel block");
        doReset();
        applyStimulus(0, 64, 32'h3F800000, 32'h3F800000, 8'h01, 8'h01);
        runUntilIdle("t1", 200);
        checkOutput("t1 ch0 results", 64'(rcv[0]), 64'd64);
        checkOutput("t1 other results", 64'(rcv[1] + rcv[2]), 64'd0);
        checkOutput("t1 ch0 lasts", 64'(last_cnt[0]), 64'd1);
        checkOutput("t1 latency", 64'(first_out_cyc - first_xfer_cyc), 64'(CVT_LAT + 2));
        checkClean("t1");

        $display("[TB] three channels contending");
        doReset();
        applyStimulus(0, 128, 32'h3F800000, 32'h40000000, 8'h01, 8'h02);
        applyStimulus(1, 64, 32'h40400000, 32'h40A00000, 8'h03, 8'h05);
        applyStimulus(2, 64, 32'hC0000000, 32'h42FECCCD, 8'hFE, 8'h7F);
        runUntilIdle("t2", 400);
        checkOutput("t2 block order", order_code(), 64'h1231);
        checkOutput("t2 idle cycles", 64'(idle_cnt), 64'd4);
        checkOutput("t2 ch0 results", 64'(rcv[0]), 64'd128);
        checkOutput("t2 ch1 results", 64'(rcv[1]), 64'd64);
        checkOutput("t2 ch2 results", 64'(rcv[2]), 64'd64);
        checkClean("t2");

        $display("[TB] requester bubble mid-block");
        doReset();
        applyStimulus(1, 64, 32'h40400000, 32'h40A00000, 8'h03, 8'h05);
        applyStimulus(2, 64, 32'hC0000000, 32'h42FECCCD, 8'hFE, 8'h7F);
        n = 0;
        while (sent[1] < 20 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("t3 reached beat 20", 64'(sent[1]), 64'd20);
        pause[1] = 1'b1;
        driveInputs();
        for (int k = 0; k < 5; k++) begin
            checkOutput("t3 grant held on ch1", 64'(req_ready), 64'b010);
            tick();
        end
        pause[1] = 1'b0;
        driveInputs();
        runUntilIdle("t3", 300);
        checkOutput("t3 block order", order_code(), 64'h23);
        checkOutput("t3 ch1 results", 64'(rcv[1]), 64'd64);
        checkOutput("t3 ch1 lasts", 64'(last_cnt[1]), 64'd1);
        checkClean("t3");

        $display("[TB] negative and saturating values");
        doReset();
        applyStimulus(2, 64, 32'hC0000000, 32'h42FECCCD, 8'hFE, 8'h7F);
        runUntilIdle("t4", 200);
        checkOutput("t4 first ch2 data", 64'(ch2_data[0]), 64'hFE);
        checkOutput("t4 second ch2 data", 64'(ch2_data[1]), 64'h7F);
        checkOutput("t4 ch2 results", 64'(rcv[2]), 64'd64);
        checkClean("t4");

        $display("[TB] reset mid-burst");
        doReset();
        applyStimulus(0, 64, 32'h3F800000, 32'h40000000, 8'h01, 8'h02);
        applyStimulus(1, 64, 32'h40400000, 32'h40A00000, 8'h03, 8'h05);
        applyStimulus(2, 64, 32'hC0000000, 32'h42FECCCD, 8'hFE, 8'h7F);
        n = 0;
        while (sent[1] < 30 && n < 300) begin
            tick();
            n++;
        end
        checkOutput("t5 reached ch1 beat 30", 64'(sent[1]), 64'd30);
        nrst = 1'b0;
        #1;
        checkOutput("t5 outputs cleared",
                    {13'd0, req_ready, cvt_din_valid, cvt_din, out_data, out_valid, out_last, sync_err}, 64'd0);
        doReset();
        repeat (12) tick();
        checkOutput("t5 stale results", 64'(rcv[0] + rcv[1] + rcv[2]), 64'd0);
        applyStimulus(0, 64, 32'h3F800000, 32'h40000000, 8'h01, 8'h02);
        applyStimulus(1, 64, 32'h40400000, 32'h40A00000, 8'h03, 8'h05);
        applyStimulus(2, 64, 32'hC0000000, 32'h42FECCCD, 8'hFE, 8'h7F);
        tick();
        checkOutput("t5 ch0 granted first", 64'(req_ready), 64'b001);
        runUntilIdle("t5", 400);
        checkOutput("t5 block order", order_code(), 64'h123);
        checkClean("t5");

        $display("[TB] converter sync error");
        doReset();
        applyStimulus(0, 0, 32'h0, 32'h0, 8'h00, 8'h00);
        repeat (3) tick();
        checkOutput("t6 sync_err before", 64'(sync_err), 64'd0);
        inject_valid = 1'b1;
        tick();
        inject_valid = 1'b0;
        repeat (CVT_LAT + 1) tick();
        checkOutput("t6 sync_err set", 64'(sync_err), 64'd1);
        checkOutput("t6 injected result on ch0", 64'(rcv[0]), 64'd1);
        repeat (20) tick();
        checkOutput("t6 sync_err sticky", 64'(sync_err), 64'd1);
        doReset();
        #1;
        checkOutput("t6 sync_err cleared by reset", 64'(sync_err), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
